axi4l_regs_bridge: RTL and testbench
====================================

Name: axi4l_regs_bridge

Overview:
AXI4-Lite slave that converts single AXI4-Lite read and write transactions into a simple request/acknowledge register bus (reg_*). It sits between the system AXI4-Lite interconnect (the team's axi4l_if bundle, flattened onto s_axi_* ports) and a user register file. One transaction is in flight at a time. A register bus that never acknowledges is terminated by a timeout with SLVERR.

Parameters:
AXI_ADDR_WIDTH, 32, AXI address width (byte address)
AXI_DATA_WIDTH, 32, AXI data width; wstrb width is AXI_DATA_WIDTH/8
REG_ADDR_WIDTH, 4, register word-index width (2**REG_ADDR_WIDTH registers)
REG_DATA_WIDTH, 32, register data width; must be <= AXI_DATA_WIDTH
ACK_TIMEOUT, 16, max cycles reg_req is held waiting for reg_ack

Ports:
axi4l_aclk  in  1  clock; all logic is rising-edge
axi4l_arstn  in  1  reset, asynchronous, active-high
s_axi_awaddr  in  AXI_ADDR_WIDTH  write address
s_axi_awvalid / s_axi_awready  in / out  1  AW handshake
s_axi_wdata  in  AXI_DATA_WIDTH  write data
s_axi_wstrb  in  AXI_DATA_WIDTH/8  write strobes
s_axi_wvalid / s_axi_wready  in / out  1  W handshake
s_axi_bresp  out  2  write response
s_axi_bvalid / s_axi_bready  out / in  1  B handshake
s_axi_araddr  in  AXI_ADDR_WIDTH  read address
s_axi_arvalid / s_axi_arready  in / out  1  AR handshake
s_axi_rdata  out  AXI_DATA_WIDTH  read data
s_axi_rresp  out  2  read response
s_axi_rvalid / s_axi_rready  out / in  1  R handshake
reg_addr  out  REG_ADDR_WIDTH  register word index
reg_wdata  out  REG_DATA_WIDTH  write data
reg_wren  out  1  write qualifier
reg_rdata  in  REG_DATA_WIDTH  read data, valid when reg_ack=1
reg_rden  out  1  read qualifier
reg_req  out  1  request strobe, held until ack or timeout
reg_ack  in  1  single-cycle acknowledge

Behaviour:
- Reset (axi4l_arstn=1, async): all outputs 0, state IDLE, AW/W/AR holding buffers empty, timeout counter 0.
- AW, W, AR are each captured in a one-entry buffer. awready/wready/arready = 1 when the respective buffer is empty and reset is deasserted; a handshake fills the buffer at the clock edge. AW and W may arrive in any order or together.
- Address mapping: reg_addr = addr[REG_ADDR_WIDTH+1:2]. Bits [1:0] and bits above are ignored, so addresses alias.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- IDLE -> WR_REQ when AW and W are both buffered. IDLE -> RD_REQ when AR is buffered. If both are ready, the write goes first, except when the previous served transaction was a write; then the read goes first (alternating, no starvation).
- WR_REQ: reg_req=1, reg_wren=1, reg_addr and reg_wdata (wdata[REG_DATA_WIDTH-1:0]) stable. On reg_ack=1: drop reg_req the next cycle, go to WR_RESP with bresp=OKAY (2'b00).
- Partial strobe: if wstrb is not all ones, no register access occurs; go directly to WR_RESP with bresp=SLVERR (2'b10).
- RD_REQ: reg_req=1, reg_rden=1. On reg_ack=1: capture reg_rdata zero-extended into rdata, go to RD_RESP with rresp=OKAY.
- Timeout: the counter increments each cycle in WR_REQ/RD_REQ. When reg_ack is still 0 after ACK_TIMEOUT cycles: drop reg_req, respond SLVERR; rdata=0 for reads.
- WR_RESP: bvalid=1 until bready; then clear the AW/W buffers and go to IDLE. RD_RESP: rvalid=1, rdata/rresp stable until rready; then clear the AR buffer and go to IDLE.
- Minimum latency: buffer fill edge -> reg_req asserted 1 cycle later; ack edge -> valid 1 cycle later.
- reg_ack outside REQ states is ignored. reg_wren and reg_rden are never both 1. reg_wren/reg_rden are 0 whenever reg_req is 0.
- Reset mid-transaction aborts immediately. No response is issued for the aborted transaction.

Decomposition:
- Package axi4l_pkg: resp constants OKAY=2'b00, SLVERR=2'b10; state enum type.
- One sub-module is natural: axi4l_ack_timer, a counter with start/clear and an expired flag.

Test Plan:
- Read 0x0, reg_ack 2 cycles after reg_req with reg_rdata=0xDEADBEEF -> reg_addr=0, reg_rden=1, rdata=0xDEADBEEF, rresp=00.
- Write 0x8 data 0x12345678 wstrb=0xF (W before AW) -> reg_addr=2, reg_wren=1, reg_wdata=0x12345678, bresp=00.
- Read 0x4 with reg_ack held low -> reg_req drops after 16 cycles, rresp=10, rdata=0.
- Write 0xC wstrb=0x3 -> no reg_req, bresp=10.
- AR and AW+W presented in the same cycle, then repeated -> write first, read second, both responses OKAY.
- Assert axi4l_arstn during RD_REQ -> all outputs 0 immediately; the next read completes normally.

Source files
------------

// File: rtl/axi4l_pkg.sv
// Shared definitions for the AXI4-Lite to register-bus bridge.
//   OKAY / SLVERR : AXI response encodings
//   state_t       : bridge transaction state
package axi4l_pkg;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_REQ  = 3'd1,
      ST_WR_RESP = 3'd2,
      ST_RD_REQ  = 3'd3,
      ST_RD_RESP = 3'd4
   } state_t;

endpackage

// File: rtl/axi4l_ack_timer.sv
// Cycle counter bounding how long a register request waits for its ack.
//   axi4l_aclk  : clock
//   axi4l_arstn : async reset, active-high
//   i_clr       : return the count to zero (has priority)
//   i_en        : count one cycle
//   o_expired   : ACK_TIMEOUT cycles have elapsed including the current one
module axi4l_ack_timer #(
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input  logic axi4l_aclk,
   input  logic axi4l_arstn,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

   logic [CNT_W-1:0] r_count;

   // Counts completed waiting cycles; cleared whenever no request is pending.
   always_ff @(posedge axi4l_aclk or posedge axi4l_arstn) begin
      if (axi4l_arstn) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   // Flag on the last allowed cycle so the request drops after exactly ACK_TIMEOUT cycles.
   assign o_expired = (r_count == CNT_W'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/axi4l_regs_bridge.sv
// AXI4-Lite slave converting single reads/writes into a req/ack register bus.
//   axi4l_aclk, axi4l_arstn       : clock, async active-high reset
//   s_axi_aw*/w*/b*/ar*/r*        : AXI4-Lite slave channels
//   reg_addr/wdata/wren/rden/req  : register bus request (held until ack/timeout)
//   reg_rdata/reg_ack             : register bus response
module axi4l_regs_bridge
   import axi4l_pkg::*;
#(
   parameter int unsigned AXI_ADDR_WIDTH = 32,
   parameter int unsigned AXI_DATA_WIDTH = 32,
   parameter int unsigned REG_ADDR_WIDTH = 4,
   parameter int unsigned REG_DATA_WIDTH = 32,
   parameter int unsigned ACK_TIMEOUT    = 16
) (
   input  logic                        axi4l_aclk,
   input  logic                        axi4l_arstn,
   input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic                        s_axi_awvalid,
   output logic                        s_axi_awready,
   input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                        s_axi_wvalid,
   output logic                        s_axi_wready,
   output logic [1:0]                  s_axi_bresp,
   output logic                        s_axi_bvalid,
   input  logic                        s_axi_bready,
   input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic                        s_axi_arvalid,
   output logic                        s_axi_arready,
   output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]                  s_axi_rresp,
   output logic                        s_axi_rvalid,
   input  logic                        s_axi_rready,
   output logic [REG_ADDR_WIDTH-1:0]   reg_addr,
   output logic [REG_DATA_WIDTH-1:0]   reg_wdata,
   output logic                        reg_wren,
   input  logic [REG_DATA_WIDTH-1:0]   reg_rdata,
   output logic                        reg_rden,
   output logic                        reg_req,
   input  logic                        reg_ack
);

   localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

   state_t                    r_state;
   logic                      r_aw_full;
   logic                      r_w_full;
   logic                      r_ar_full;
   logic                      r_last_wr;
   logic [REG_ADDR_WIDTH-1:0] r_awaddr;
   logic [REG_ADDR_WIDTH-1:0] r_araddr;
   logic [REG_DATA_WIDTH-1:0] r_wdata;
   logic [STRB_W-1:0]         r_wstrb;

   logic w_in_req;
   logic w_expired;
   logic w_wr_go;
   logic w_rd_go;
   logic w_unused;

   // Address bits outside the word index and excess data bits are intentionally dropped.
   assign w_unused = ^{s_axi_awaddr, s_axi_araddr, s_axi_wdata};

   // Each channel accepts a new beat only while its one-entry buffer is empty.
   assign s_axi_awready = ~r_aw_full & ~axi4l_arstn;
   assign s_axi_wready  = ~r_w_full  & ~axi4l_arstn;
   assign s_axi_arready = ~r_ar_full & ~axi4l_arstn;

   assign w_in_req = (r_state == ST_WR_REQ) || (r_state == ST_RD_REQ);

   // Write wins a tie unless the last served transaction was a write.
   assign w_wr_go = r_aw_full & r_w_full & (~r_ar_full | ~r_last_wr);
   assign w_rd_go = r_ar_full & ~w_wr_go;

   axi4l_ack_timer #(
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) u_ack_timer (
      .axi4l_aclk  (axi4l_aclk),
      .axi4l_arstn (axi4l_arstn),
      .i_clr       (~w_in_req),
      .i_en        (w_in_req),
      .o_expired   (w_expired)
   );

   // Channel buffers and transaction FSM with registered outputs.
   always_ff @(posedge axi4l_aclk or posedge axi4l_arstn) begin
      if (axi4l_arstn) begin
         r_state      <= ST_IDLE;
         r_aw_full    <= 1'b0;
         r_w_full     <= 1'b0;
         r_ar_full    <= 1'b0;
         r_last_wr    <= 1'b0;
         r_awaddr     <= '0;
         r_araddr     <= '0;
         r_wdata      <= '0;
         r_wstrb      <= '0;
         s_axi_bresp  <= OKAY;
         s_axi_bvalid <= 1'b0;
         s_axi_rdata  <= '0;
         s_axi_rresp  <= OKAY;
         s_axi_rvalid <= 1'b0;
         reg_addr     <= '0;
         reg_wdata    <= '0;
         reg_wren     <= 1'b0;
         reg_rden     <= 1'b0;
         reg_req      <= 1'b0;
      end else begin
         if (s_axi_awvalid && s_axi_awready) begin
            r_aw_full <= 1'b1;
            r_awaddr  <= s_axi_awaddr[REG_ADDR_WIDTH+1:2];
         end
         if (s_axi_wvalid && s_axi_wready) begin
            r_w_full <= 1'b1;
            r_wdata  <= s_axi_wdata[REG_DATA_WIDTH-1:0];
            r_wstrb  <= s_axi_wstrb;
         end
         if (s_axi_arvalid && s_axi_arready) begin
            r_ar_full <= 1'b1;
            r_araddr  <= s_axi_araddr[REG_ADDR_WIDTH+1:2];
         end

         case (r_state)
            ST_IDLE: begin
               if (w_wr_go) begin
                  r_last_wr <= 1'b1;
                  // A partial-strobe write never reaches the register file.
                  if (&r_wstrb) begin
                     r_state   <= ST_WR_REQ;
                     reg_req   <= 1'b1;
                     reg_wren  <= 1'b1;
                     reg_addr  <= r_awaddr;
                     reg_wdata <= r_wdata;
                  end else begin
                     r_state      <= ST_WR_RESP;
                     s_axi_bvalid <= 1'b1;
                     s_axi_bresp  <= SLVERR;
                  end
               end else if (w_rd_go) begin
                  r_last_wr <= 1'b0;
                  r_state   <= ST_RD_REQ;
                  reg_req   <= 1'b1;
                  reg_rden  <= 1'b1;
                  reg_addr  <= r_araddr;
               end
            end

            ST_WR_REQ: begin
               if (reg_ack || w_expired) begin
                  r_state      <= ST_WR_RESP;
                  reg_req      <= 1'b0;
                  reg_wren     <= 1'b0;
                  s_axi_bvalid <= 1'b1;
                  s_axi_bresp  <= reg_ack ? OKAY : SLVERR;
               end
            end

            ST_WR_RESP: begin
               if (s_axi_bready) begin
                  r_state      <= ST_IDLE;
                  s_axi_bvalid <= 1'b0;
                  r_aw_full    <= 1'b0;
                  r_w_full     <= 1'b0;
               end
            end

            ST_RD_REQ: begin
               if (reg_ack || w_expired) begin
                  r_state      <= ST_RD_RESP;
                  reg_req      <= 1'b0;
                  reg_rden     <= 1'b0;
                  s_axi_rvalid <= 1'b1;
                  s_axi_rresp  <= reg_ack ? OKAY : SLVERR;
                  s_axi_rdata  <= reg_ack ? AXI_DATA_WIDTH'(reg_rdata) : '0;
               end
            end

            ST_RD_RESP: begin
               if (s_axi_rready) begin
                  r_state      <= ST_IDLE;
                  s_axi_rvalid <= 1'b0;
                  r_ar_full    <= 1'b0;
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi4l_regs_bridge.sv
// Self-checking bench for axi4l_regs_bridge: directed cases followed by
// randomized transactions scored against an array model of the register file.
module tb_axi4l_regs_bridge;

   localparam logic [1:0] R_OKAY   = 2'b00;
   localparam logic [1:0] R_SLVERR = 2'b10;

   logic        axi4l_aclk  = 1'b0;
   logic        axi4l_arstn = 1'b1;
   logic [31:0] s_axi_awaddr = '0;
   logic        s_axi_awvalid = 1'b0;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata = '0;
   logic [3:0]  s_axi_wstrb = '0;
   logic        s_axi_wvalid = 1'b0;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready = 1'b0;
   logic [31:0] s_axi_araddr = '0;
   logic        s_axi_arvalid = 1'b0;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid;
   logic        s_axi_rready = 1'b0;
   logic [3:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic        reg_wren;
   logic [31:0] reg_rdata;
   logic        reg_rden;
   logic        reg_req;
   logic        reg_ack;

   always #5 axi4l_aclk = ~axi4l_aclk;

   axi4l_regs_bridge dut (
      .axi4l_aclk    (axi4l_aclk),
      .axi4l_arstn   (axi4l_arstn),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wstrb   (s_axi_wstrb),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_bresp   (s_axi_bresp),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready),
      .s_axi_araddr  (s_axi_araddr),
      .s_axi_arvalid (s_axi_arvalid),
      .s_axi_arready (s_axi_arready),
      .s_axi_rdata   (s_axi_rdata),
      .s_axi_rresp   (s_axi_rresp),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rready  (s_axi_rready),
      .reg_addr      (reg_addr),
      .reg_wdata     (reg_wdata),
      .reg_wren      (reg_wren),
      .reg_rdata     (reg_rdata),
      .reg_rden      (reg_rden),
      .reg_req       (reg_req),
      .reg_ack       (reg_ack)
   );

   typedef struct {
      bit          wr;
      bit          rd;
      logic [3:0]  addr;
      logic [31:0] data;
   } acc_t;

   acc_t        log_q[$];
   logic [31:0] regfile  [16];
   logic [31:0] exp_regs [16];
   bit          ack_en    = 1'b1;
   int          ack_delay = 0;
   int          wait_cnt;
   int          n_assert  = 0;
   int          n_fail    = 0;
   bit          last_wr   = 1'b0;

   function automatic logic [31:0] init_val(input int i);
      return (i == 0) ? 32'hDEAD_BEEF : 32'h1000_0000 + 32'(i) * 32'h0101_0101;
   endfunction

   // Register-file responder: acks after ack_delay waiting cycles, logs every access.
   always @(posedge axi4l_aclk or posedge axi4l_arstn) begin
      if (axi4l_arstn) begin
         reg_ack   <= 1'b0;
         reg_rdata <= '0;
         wait_cnt  <= 0;
         for (int i = 0; i < 16; i++) regfile[i] <= init_val(i);
      end else begin
         reg_ack <= 1'b0;
         if (reg_req && !reg_ack) begin
            if (ack_en && wait_cnt >= ack_delay) begin
               reg_ack  <= 1'b1;
               wait_cnt <= 0;
               if (reg_wren) regfile[reg_addr] <= reg_wdata;
               else          reg_rdata <= regfile[reg_addr];
               log_q.push_back('{reg_wren, reg_rden, reg_addr,
                                 reg_wren ? reg_wdata : regfile[reg_addr]});
            end else begin
               wait_cnt <= wait_cnt + 1;
            end
         end else begin
            wait_cnt <= 0;
         end
      end
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge axi4l_aclk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) exp_regs[i] = init_val(i);
      last_wr = 1'b0;
   endtask

   // Presents the requested channels together and retires each on its own handshake.
   task automatic issue(input bit aw, input bit w, input bit ar,
                        input logic [31:0] awaddr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic [31:0] araddr);
      bit pa = aw;
      bit pw = w;
      bit pr = ar;
      int n  = 0;
      s_axi_awaddr  = awaddr;
      s_axi_wdata   = wdata;
      s_axi_wstrb   = wstrb;
      s_axi_araddr  = araddr;
      s_axi_awvalid = pa;
      s_axi_wvalid  = pw;
      s_axi_arvalid = pr;
      while ((pa || pw || pr) && n < 50) begin
         bit ha = pa && s_axi_awready;
         bit hw = pw && s_axi_wready;
         bit hr = pr && s_axi_arready;
         step();
         if (ha) begin pa = 1'b0; s_axi_awvalid = 1'b0; end
         if (hw) begin pw = 1'b0; s_axi_wvalid  = 1'b0; end
         if (hr) begin pr = 1'b0; s_axi_arvalid = 1'b0; end
         n++;
      end
      chk("handshake_pending", {pa, pw, pr}, 3'b000);
   endtask

   task automatic get_b(output logic [1:0] resp);
      int n = 0;
      while (!s_axi_bvalid && n < 200) begin step(); n++; end
      chk("bvalid_seen", s_axi_bvalid, 1'b1);
      resp = s_axi_bresp;
      s_axi_bready = 1'b1;
      step();
      s_axi_bready = 1'b0;
      chk("bvalid_drop", s_axi_bvalid, 1'b0);
   endtask

   task automatic get_r(output logic [31:0] data, output logic [1:0] resp);
      int n = 0;
      while (!s_axi_rvalid && n < 200) begin step(); n++; end
      chk("rvalid_seen", s_axi_rvalid, 1'b1);
      data = s_axi_rdata;
      resp = s_axi_rresp;
      s_axi_rready = 1'b1;
      step();
      s_axi_rready = 1'b0;
      chk("rvalid_drop", s_axi_rvalid, 1'b0);
   endtask

   // mode 0: AW and W together, 1: W before AW, 2: AW before W.
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int mode);
      logic [3:0] idx  = addr[5:2];
      bit         hits = (strb == 4'hF) && ack_en;
      logic [1:0] resp;
      log_q.delete();
      case (mode)
         1:       begin issue(0, 1, 0, addr, data, strb, '0); issue(1, 0, 0, addr, data, strb, '0); end
         2:       begin issue(1, 0, 0, addr, data, strb, '0); issue(0, 1, 0, addr, data, strb, '0); end
         default: issue(1, 1, 0, addr, data, strb, '0);
      endcase
      get_b(resp);
      if (hits) exp_regs[idx] = data;
      chk("bresp", resp, hits ? R_OKAY : R_SLVERR);
      chk("wr_access_count", log_q.size(), hits ? 1 : 0);
      if (hits && log_q.size() > 0)
         chk("wr_access", {log_q[0].wr, log_q[0].rd, log_q[0].addr, log_q[0].data},
             {1'b1, 1'b0, idx, data});
      last_wr = 1'b1;
   endtask

   task automatic do_read(input logic [31:0] addr);
      logic [3:0]  idx = addr[5:2];
      logic [31:0] data;
      logic [1:0]  resp;
      log_q.delete();
      issue(0, 0, 1, '0, '0, '0, addr);
      get_r(data, resp);
      chk("rdata", data, ack_en ? exp_regs[idx] : 32'h0);
      chk("rresp", resp, ack_en ? R_OKAY : R_SLVERR);
      chk("rd_access_count", log_q.size(), ack_en ? 1 : 0);
      if (ack_en && log_q.size() > 0)
         chk("rd_access", {log_q[0].wr, log_q[0].rd, log_q[0].addr}, {1'b0, 1'b1, idx});
      last_wr = 1'b0;
   endtask

   // AW+W and AR in the same cycle; the served order follows the alternation rule.
   task automatic do_pair(input logic [31:0] waddr, input logic [31:0] wdata,
                          input logic [31:0] raddr);
      logic [3:0]  widx = waddr[5:2];
      logic [3:0]  ridx = raddr[5:2];
      bit          wr_first = !last_wr;
      bit          got_b = 1'b0, got_r = 1'b0, first_wr = 1'b0;
      logic [31:0] exp_rd, rdata;
      logic [1:0]  bresp, rresp;
      int          n = 0;
      if (wr_first) begin
         if (ack_en) exp_regs[widx] = wdata;
         exp_rd = ack_en ? exp_regs[ridx] : 32'h0;
      end else begin
         exp_rd = ack_en ? exp_regs[ridx] : 32'h0;
         if (ack_en) exp_regs[widx] = wdata;
      end
      log_q.delete();
      issue(1, 1, 1, waddr, wdata, 4'hF, raddr);
      s_axi_bready = 1'b1;
      s_axi_rready = 1'b1;
      while (!(got_b && got_r) && n < 300) begin
         if (s_axi_bvalid && !got_b) begin got_b = 1'b1; bresp = s_axi_bresp; first_wr = !got_r; end
         if (s_axi_rvalid && !got_r) begin got_r = 1'b1; rresp = s_axi_rresp; rdata = s_axi_rdata; end
         if (!(got_b && got_r)) step();
         n++;
      end
      step();
      s_axi_bready = 1'b0;
      s_axi_rready = 1'b0;
      chk("pair_both_seen", {got_b, got_r}, 2'b11);
      chk("pair_write_first", first_wr, wr_first);
      chk("pair_bresp", bresp, ack_en ? R_OKAY : R_SLVERR);
      chk("pair_rresp", rresp, ack_en ? R_OKAY : R_SLVERR);
      chk("pair_rdata", rdata, exp_rd);
      chk("pair_access_count", log_q.size(), ack_en ? 2 : 0);
      if (ack_en && log_q.size() > 0) chk("pair_access_order", log_q[0].wr, wr_first);
      last_wr = !wr_first;
   endtask

   initial begin
      logic [31:0] data;
      logic [1:0]  resp;
      int          hi;
      int          n;

      model_reset();
      step();
      step();
      chk("reset_reg_outputs", {reg_req, reg_wren, reg_rden, reg_addr, reg_wdata}, '0);
      chk("reset_axi_flags", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid,
                              s_axi_rvalid, s_axi_bresp, s_axi_rresp}, '0);
      chk("reset_rdata", s_axi_rdata, '0);
      axi4l_arstn = 1'b0;
      step();
      chk("ready_after_reset", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

      // Read word 0, ack two cycles after the request.
      ack_delay = 1;
      do_read(32'h0000_0000);

      // Write word 2 with W ahead of AW, then read it back.
      ack_delay = 0;
      do_write(32'h0000_0008, 32'h1234_5678, 4'hF, 1);

      // Read of word 1 that is never acknowledged.
      ack_en = 1'b0;
      log_q.delete();
      hi = 0;
      n  = 0;
      issue(0, 0, 1, '0, '0, '0, 32'h0000_0004);
      while (!s_axi_rvalid && n < 100) begin
         if (reg_req) hi++;
         chk("rd_qualifiers", {reg_wren, reg_rden}, reg_req ? 2'b01 : 2'b00);
         step();
         n++;
      end
      chk("timeout_req_cycles", hi, 16);
      get_r(data, resp);
      chk("timeout_rdata", data, 32'h0);
      chk("timeout_rresp", resp, R_SLVERR);
      chk("timeout_no_access", log_q.size(), 0);
      last_wr = 1'b0;
      ack_en  = 1'b1;

      // Partial strobe: rejected without a register access.
      do_write(32'h0000_000C, 32'hCAFE_F00D, 4'h3, 0);

      do_read(32'h0000_0008);
      do_pair(32'h0000_0010, 32'hA5A5_0001, 32'h0000_0014);
      do_pair(32'h0000_0014, 32'h5A5A_0002, 32'h0000_0010);

      // Randomized mix with aliased addresses, random ack latency and occasional timeouts.
      for (int i = 0; i < 30; i++) begin
         int          op   = $urandom_range(0, 2);
         logic [31:0] a    = $urandom;
         logic [31:0] b    = $urandom;
         logic [31:0] d    = $urandom;
         logic [3:0]  strb = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
         ack_delay = $urandom_range(0, 4);
         ack_en    = ($urandom_range(0, 7) != 0);
         case (op)
            0:       do_read(a);
            1:       do_write(a, d, strb, $urandom_range(0, 2));
            default: do_pair(a, d, b);
         endcase
      end

      // Reset while a read request is outstanding.
      ack_en = 1'b0;
      log_q.delete();
      issue(0, 0, 1, '0, '0, '0, 32'h0000_0024);
      n = 0;
      while (!reg_req && n < 20) begin step(); n++; end
      chk("abort_req_seen", reg_req, 1'b1);
      step();
      axi4l_arstn = 1'b1;
      #1;
      chk("abort_reg_outputs", {reg_req, reg_wren, reg_rden, reg_addr, reg_wdata}, '0);
      chk("abort_axi_flags", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid,
                              s_axi_rvalid, s_axi_bresp, s_axi_rresp}, '0);
      chk("abort_rdata", s_axi_rdata, '0);
      step();
      axi4l_arstn = 1'b0;
      model_reset();
      ack_en    = 1'b1;
      ack_delay = 0;
      step();
      chk("abort_ready", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
      chk("abort_no_rvalid", s_axi_rvalid, 1'b0);
      do_read(32'h0000_0024);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
